// File: rtl/sqrt_pkg.sv
// Shared definitions for the square/sqrt pair.
// Contents:
//   state_t : controller states {IDLE, CALC, DONE}
//   ROOT_W  : default root width in bits
//   N_W     : width of the signed N value exchanged with the sqrt unit
//   N_MAX   : largest positive N (saturation ceiling for the squarer)
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int ROOT_W = 8;
  localparam int N_W    = 16;
  localparam logic signed [N_W-1:0] N_MAX = 16'sd32767;

endpackage

// File: rtl/square_datapath.sv
// Shift-add datapath for square_seq: operand registers, accumulator and the
// saturating result register.
// Optional build macro: SQUARE_EARLY_EXIT_EN (adds the rest_zero flag).
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   rest_zero    : (early-exit build) multiplier bits above the current one are all 0
//   load         : latch root into multiplicand/multiplier, clear accumulator
//   step         : add the current partial product and shift the multiplier
//   finish       : register the saturated result/invalid this edge
//   root         : unsigned operand
//   cnt          : bit position of the multiplier bit being processed
//   result       : saturated square, held until the next finish
//   invalid      : square exceeded the signed range
module square_datapath
  import sqrt_pkg::*;
#(
  parameter int WIDTH = ROOT_W,
  parameter int CW    = 3
) (
  input  logic               clock,
  input  logic               reset,
`ifdef SQUARE_EARLY_EXIT_EN
  output logic               rest_zero,
`endif
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic [WIDTH-1:0]   root,
  input  logic [CW-1:0]      cnt,
  output logic [2*WIDTH-1:0] result,
  output logic               invalid
);

  localparam int RW = 2 * WIDTH;
  localparam logic [RW-1:0] SAT_MAX = {1'b0, {(RW-1){1'b1}}};

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    addend;
  logic [RW-1:0]    sum;
  logic [RW-1:0]    final_v;

  always_comb begin
    addend = '0;
    if (mplier[0]) addend = {{WIDTH{1'b0}}, mcand} << cnt;
  end

  assign sum = acc + addend;

  // A finish coinciding with load only happens for root=0 in the early-exit
  // build, where the square is trivially zero.
  assign final_v = load ? '0 : sum;

`ifdef SQUARE_EARLY_EXIT_EN
  assign rest_zero = (mplier >> 1) == '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      result  <= '0;
      invalid <= 1'b0;
    end else begin
      if (load) begin
        mcand  <= root;
        mplier <= root;
        acc    <= '0;
      end else if (step) begin
        acc    <= sum;
        mplier <= mplier >> 1;
      end
      if (finish) begin
        if (final_v > SAT_MAX) begin
          result  <= SAT_MAX;
          invalid <= 1'b1;
        end else begin
          result  <= final_v;
          invalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/square_seq.sv
// Sequential shift-add squarer; produces the signed N consumed by the sqrt
// unit, with the same start/done/invalid handshake. One root bit per clock.
// Optional build macro: SQUARE_EARLY_EXIT_EN (stop once no multiplier bits
// remain set; data-dependent latency).
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   root         : unsigned operand, sampled when start is accepted
//   start        : request, accepted only in IDLE
//   done         : one-cycle pulse when result/invalid are valid
//   invalid      : square exceeds the signed range
//   result       : saturated square, held until the next accepted start
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiplier bit per clock, LSB first
// DONE  | done pulse; returns to IDLE next edge
module square_seq
  import sqrt_pkg::*;
#(
  parameter int WIDTH = ROOT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   root,
  input  logic               start,
  output logic               done,
  output logic               invalid,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load;
  logic          step;
  logic          last;
  logic          finish;

  assign load = (state == IDLE) && start;
  assign step = (state == CALC);

`ifdef SQUARE_EARLY_EXIT_EN
  logic rest_zero;
  assign last   = (cnt == CW'(WIDTH - 1)) || rest_zero;
  assign finish = (step && last) || (load && (root == '0));
`else
  assign last   = (cnt == CW'(WIDTH - 1));
  assign finish = step && last;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (finish) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  square_datapath #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_datapath (
    .clock     (clock),
    .reset     (reset),
`ifdef SQUARE_EARLY_EXIT_EN
    .rest_zero (rest_zero),
`endif
    .load      (load),
    .step      (step),
    .finish    (finish),
    .root      (root),
    .cnt       (cnt),
    .result    (result),
    .invalid   (invalid)
  );

endmodule

// File: tb/tb_square_seq.sv
// Directed bench for square_seq; expected values are hand-computed squares.
module tb_square_seq;

`ifdef SQUARE_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [7:0]  root;
  logic        start;
  logic        done;
  logic        invalid;
  logic [15:0] result;

  int tests = 0;
  int fails = 0;
  int n;
  int k;
  int pulses;

  square_seq #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .root    (root),
    .start   (start),
    .done    (done),
    .invalid (invalid),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start; returns #1 after the sampling edge E0.
  task automatic launch(input logic [7:0] r);
    @(negedge clock);
    root  = r;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // n0 = cycle index already reached (1 = the cycle right after E0).
  task automatic await(input string tag, input int n0, input int exp_lat,
                       input logic [15:0] exp_res, input logic exp_inv);
    int c;
    c = n0;
    while (!done && c < 40) begin
      @(posedge clock);
      #1;
      c++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    chk({tag, "_latency"}, c, exp_lat);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_invalid"}, invalid, exp_inv);
    @(posedge clock);
    #1;
    chk({tag, "_done_falls"}, done, 1'b0);
    chk({tag, "_result_held"}, result, exp_res);
  endtask

  initial begin
    reset = 1'b1;
    root  = 8'd0;
    start = 1'b0;
    #4;
    reset = 1'b0;
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_invalid", invalid, 1'b0);
    chk("rst_result", result, 16'd0);

    launch(8'd173);
    root = 8'd7;  // must not affect the operation in flight
    await("r173", 1, 9, 16'd29929, 1'b0);

    launch(8'd181);
    await("r181", 1, 9, 16'd32761, 1'b0);

    launch(8'd182);
    await("r182", 1, 9, 16'd32767, 1'b1);

    launch(8'd0);
    await("r0", 1, EARLY ? 1 : 9, 16'd0, 1'b0);

    // Spurious start/root three cycles into CALC must be ignored.
    launch(8'd255);
    @(posedge clock);
    @(posedge clock);
    #1;
    root  = 8'd3;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    await("r255", 4, 9, 16'd32767, 1'b1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    chk("ignored_start_no_done", pulses, 0);
    chk("ignored_start_result", result, 16'd32767);

    launch(8'd3);
    await("r3", 1, EARLY ? 3 : 9, 16'd9, 1'b0);

    // Reset in the 4th CALC cycle aborts without a done pulse.
    launch(8'd100);
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 16'd0);
    chk("abort_invalid", invalid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);

    launch(8'd35);
    await("r35", 1, EARLY ? 7 : 9, 16'd1225, 1'b0);

    launch(8'd1);
    await("r1", 1, EARLY ? 2 : 9, 16'd1, 1'b0);

    launch(8'd128);
    await("r128", 1, 9, 16'd16384, 1'b0);

    // start held high: back-to-back operations.
    @(negedge clock);
    root  = 8'd3;
    start = 1'b1;
    k = 0;
    while (!done && k < 40) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("b2b_first_done", done, 1'b1);
    k = 0;
    do begin
      @(posedge clock);
      #1;
      k++;
    end while (!done && k < 40);
    start = 1'b0;
    chk("b2b_period", k, EARLY ? 4 : 10);
    chk("b2b_result", result, 16'd9);
    @(posedge clock);
    #1;
    chk("b2b_done_falls", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/square_seq.md
Name: square_seq

Overview:
- Sequential shift-add squarer; inverse operation of the sqrt unit.
- Takes an unsigned root and returns its square as a signed 16-bit N, in the same format the sqrt unit consumes.
- Uses the same start/done/invalid handshake as the sqrt unit, so a controller can chain square and sqrt back-to-back for round-trip checking.
- One operand bit is processed per clock.

Parameters:
- WIDTH, 8, root width in bits. Result width is 2*WIDTH.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- root  input  WIDTH  unsigned operand; sampled only when start is accepted.
- start  input  1  request pulse; accepted only in IDLE.
- done  output  1  one-cycle pulse when result/invalid are valid.
- invalid  output  1  square exceeds the signed range; held with result.
- result  output  2*WIDTH  signed square, saturated; held until the next accepted start.

Behaviour:
- Reset (async, active-high): state=IDLE, done=0, invalid=0, result=0, internal accumulator/operand registers=0. Reset mid-CALC aborts with no done pulse.
- States:
  - IDLE: waits for start. On a rising edge with start=1: latch root into multiplicand and multiplier registers, clear accumulator, clear bit counter, go to CALC. This is edge E0.
  - CALC: one edge per multiplier bit, LSB first. If the current bit is 1, acc += multiplicand << counter. Multiplier shifts right; counter increments. At the edge where counter reaches WIDTH-1 (E8 for WIDTH=8): register result/invalid, go to DONE.
  - DONE: done=1 for exactly this one cycle. The next edge returns to IDLE unconditionally.
- Latency: done is high during the cycle after E(WIDTH), i.e. WIDTH+1 clocks after the start-sampling edge (9 for WIDTH=8). Next start is accepted at earliest on the edge after done falls.
- Arithmetic:
  - Accumulator is 2*WIDTH unsigned bits; cannot overflow, since (2^W-1)^2 < 2^(2W).
  - If acc > 2^(2W-1)-1 (32767): invalid=1, result=32767.
  - Otherwise invalid=0 and result=acc.
- start while in CALC or DONE is ignored. root changes after E0 have no effect.
- start held high continuously: a new operation starts in every IDLE cycle (back-to-back, period WIDTH+2).
- result and invalid change only at the DONE-entry edge or on reset.

Optional Feature:
- Macro: SQUARE_EARLY_EXIT_EN
- Defined: CALC exits to DONE at the first edge after which the remaining multiplier bits are all zero. For root=0, E0 goes directly to DONE. Latency is therefore data-dependent, from 1 to WIDTH+1 clocks.
- Undefined: fixed latency of WIDTH+1.
- Result values are identical in both builds.

Decomposition:
- Shared package sqrt_pkg:
  - state enum {IDLE, CALC, DONE}
  - constants ROOT_W=8, N_W=16, N_MAX=16'sd32767
- Sub-module square_datapath holds the multiplicand/multiplier/accumulator registers, shift-add logic and saturation compare.
- The top level holds only the FSM and counter.

Test Plan:
- Reset 4ns, then root=173 with a start pulse -> done rises 9 clocks after the sampling edge; result=29929, invalid=0.
- root=181 -> result=32761, invalid=0; then root=182 -> result=32767, invalid=1 (raw 33124).
- root=0 -> result=0, invalid=0; fixed build latency 9 clocks; SQUARE_EARLY_EXIT_EN build -> done 1 clock after the sampling edge.
- root=255 -> result=32767, invalid=1. A second start pulse and root=3 applied 3 cycles into CALC -> ignored, no extra done; a later clean start with root=3 -> result=9.
- root=100, reset asserted at the 4th CALC cycle -> no done; outputs return to 0; a subsequent root=35 -> result=1225.
- SQUARE_EARLY_EXIT_EN: root=1 -> done 2 clocks after sampling, result=1; root=128 -> 9 clocks, result=16384.
